// File: rtl/cass_in_slicer.sv
// cass_in_slicer
//   Slices a signed 16-bit audio ADC stream into a one-bit cassette level.
//   The slicer uses hysteresis thresholds (HYST_HI / HYST_LO) and needs DEBOUNCE
//   consecutive qualifying samples before it changes level. It also measures
//   the period between edges, counted in valid samples.
//
//   Optional feature: define CASS_DC_BLOCK_EN to subtract a running DC estimate
//   (a first-order IIR with a 1/64 step) before comparing against the thresholds.
//   With the macro undefined, the raw sample is compared and no DC logic is built.
//
// Ports
//   BCLK         audio bit clock
//   iRST_N       asynchronous active-low reset
//   iSAMPLE      signed ADC sample
//   iSAMPLE_VLD  one-cycle strobe qualifying iSAMPLE
//   oCASS_IN     sliced level, registered (1 = high)
//   oEDGE        one-cycle pulse in the first cycle oCASS_IN shows a new level
//   oPERIOD      valid samples from the previous edge up to and including the
//                sample that completed this edge; held between edges
//   oOVF         sticky: period counter saturated at 12'hFFF since the last edge
module cass_in_slicer #(
  parameter logic signed [15:0] HYST_HI  = 16'sh0800,
  parameter logic signed [15:0] HYST_LO  = 16'shF800,
  parameter int unsigned        DEBOUNCE = 2
) (
  input  logic        BCLK,
  input  logic        iRST_N,
  input  logic [15:0] iSAMPLE,
  input  logic        iSAMPLE_VLD,
  output logic        oCASS_IN,
  output logic        oEDGE,
  output logic [11:0] oPERIOD,
  output logic        oOVF
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;

  state_t             state, stateNxt;
  logic [3:0]         dbCnt, dbCntNxt;
  logic [3:0]         dbInc;
  logic signed [15:0] cmpVal;
  logic               isHi, isLo;
  logic               levelNxt, edgeNxt;
  logic [11:0]        perCnt, perInc;

`ifdef CASS_DC_BLOCK_EN
  // DC tracker. The comparison uses the estimate from before this sample's
  // update, so the level latency is the same as without DC removal.
  logic signed [15:0] dcEst;
  logic signed [16:0] dcDiff, dcSum;

  assign dcDiff = 17'($signed(iSAMPLE)) - 17'(dcEst);
  // The new estimate lies between the old estimate and the sample, so the sum
  // always fits back into 16 bits.
  assign dcSum  = 17'(dcEst) + (dcDiff >>> 6);

  always_comb begin
    cmpVal = dcDiff[15:0];
    if (dcDiff > 17'sh07FFF)       cmpVal = 16'sh7FFF;
    else if (dcDiff < -17'sh08000) cmpVal = 16'sh8000;
  end

  always_ff @(posedge BCLK or negedge iRST_N) begin
    if (!iRST_N)          dcEst <= '0;
    else if (iSAMPLE_VLD) dcEst <= dcSum[15:0];
  end
`else
  assign cmpVal = $signed(iSAMPLE);
`endif

  assign isHi  = cmpVal > HYST_HI;
  assign isLo  = cmpVal < HYST_LO;
  assign dbInc = dbCnt + 4'd1;

  always_ff @(posedge BCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= LOW;
      dbCnt <= '0;
    end else begin
      state <= stateNxt;
      dbCnt <= dbCntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    dbCntNxt = dbCnt;
    if (iSAMPLE_VLD) begin
      unique case (state)
        LOW, RISE_PEND: begin
          if (isHi) begin
            // In LOW the count is 0, so the increment gives 1. With
            // DEBOUNCE=1 this path goes straight to HIGH.
            if (dbInc == DEB) begin
              stateNxt = HIGH;
              dbCntNxt = '0;
            end else begin
              stateNxt = RISE_PEND;
              dbCntNxt = dbInc;
            end
          end else begin
            stateNxt = LOW;
            dbCntNxt = '0;
          end
        end
        HIGH, FALL_PEND: begin
          if (isLo) begin
            if (dbInc == DEB) begin
              stateNxt = LOW;
              dbCntNxt = '0;
            end else begin
              stateNxt = FALL_PEND;
              dbCntNxt = dbInc;
            end
          end else begin
            stateNxt = HIGH;
            dbCntNxt = '0;
          end
        end
        default: begin
          stateNxt = LOW;
          dbCntNxt = '0;
        end
      endcase
    end
  end

  assign levelNxt = (stateNxt == HIGH) || (stateNxt == FALL_PEND);
  assign edgeNxt  = iSAMPLE_VLD && (levelNxt != oCASS_IN);
  assign perInc   = (perCnt == 12'hFFF) ? 12'hFFF : perCnt + 12'd1;

  always_ff @(posedge BCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oCASS_IN <= 1'b0;
      oEDGE    <= 1'b0;
      oPERIOD  <= '0;
      oOVF     <= 1'b0;
      perCnt   <= '0;
    end else begin
      oEDGE <= edgeNxt;
      if (iSAMPLE_VLD) begin
        oCASS_IN <= levelNxt;
        if (edgeNxt) begin
          // The completing sample counts toward the reported period.
          oPERIOD <= perInc;
          perCnt  <= '0;
          oOVF    <= 1'b0;
        end else begin
          perCnt <= perInc;
          if (perInc == 12'hFFF) oOVF <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cass_in_slicer.sv
module tb_cass_in_slicer;
  localparam int HI  = 2048;
  localparam int LO  = -2048;
  localparam int DEB = 2;

  logic        BCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [15:0] iSAMPLE = '0;
  logic        iSAMPLE_VLD = 1'b0;
  logic        oCASS_IN, oEDGE, oOVF;
  logic [11:0] oPERIOD;

  int nChk = 0, nPass = 0;

  // Reference state: level, run of qualifying samples, and the number of
  // valid samples since the last edge (unbounded; clamped when reported).
  int mLvl = 0, mRun = 0, mN = 0, mPer = 0, mEdge = 0, mOvf = 0, mDc = 0;
  int nEdges = 0;

  cass_in_slicer dut (
    .BCLK(BCLK), .iRST_N(iRST_N), .iSAMPLE(iSAMPLE), .iSAMPLE_VLD(iSAMPLE_VLD),
    .oCASS_IN(oCASS_IN), .oEDGE(oEDGE), .oPERIOD(oPERIOD), .oOVF(oOVF)
  );

  always #5 BCLK = ~BCLK;

  task automatic chk(input string tag, input int obs, input int exp);
    nChk++;
    if (obs == exp) nPass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
  endtask

  function automatic int cmpOf(input logic [15:0] s);
    int v;
    v = int'($signed(s));
`ifdef CASS_DC_BLOCK_EN
    v = v - mDc;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v;
  endfunction

  task automatic modelReset();
    mLvl = 0; mRun = 0; mN = 0; mPer = 0; mEdge = 0; mOvf = 0; mDc = 0;
  endtask

  task automatic modelStep(input logic vld, input logic [15:0] s);
    int  v;
    bit  q;
    mEdge = 0;
    if (!vld) return;
    v = cmpOf(s);
`ifdef CASS_DC_BLOCK_EN
    mDc = mDc + ((int'($signed(s)) - mDc) >>> 6);
`endif
    q = mLvl ? (v < LO) : (v > HI);
    mRun = q ? mRun + 1 : 0;
    mN++;
    if (mRun == DEB) begin
      mLvl  = 1 - mLvl;
      mRun  = 0;
      mEdge = 1;
      nEdges++;
      mPer  = (mN > 4095) ? 4095 : mN;
      mN    = 0;
    end
    mOvf = (mN >= 4095);
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".cass"}, oCASS_IN, mLvl);
    chk({tag, ".edge"}, oEDGE, mEdge);
    chk({tag, ".period"}, oPERIOD, mPer);
    chk({tag, ".ovf"}, oOVF, mOvf);
  endtask

  task automatic step(input logic vld, input logic [15:0] s, input string tag);
    @(negedge BCLK);
    iSAMPLE_VLD = vld;
    iSAMPLE = vld ? s : 16'($urandom);
    @(posedge BCLK);
    #1;
    modelStep(vld, s);
    checkAll(tag);
  endtask

  task automatic doReset();
    @(negedge BCLK);
    iRST_N = 1'b0;
    iSAMPLE_VLD = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    @(negedge BCLK);
    iRST_N = 1'b1;
  endtask

  initial begin
    #12;
    modelReset();
    checkAll("por");
    @(negedge BCLK);
    iRST_N = 1'b1;

`ifdef CASS_DC_BLOCK_EN
    // A constant offset: one rise, then the corrected value settles in the band.
    nEdges = 0;
    for (int i = 0; i < 400; i++) step(1'b1, 16'h3000, "dc_const");
    chk("dc_one_edge", nEdges, 1);
    chk("dc_still_high", oCASS_IN, 1);
    doReset();
    step(1'b1, 16'h3000, "dc_pend");
    doReset();
    step(1'b0, 16'h0000, "dc_after_rst");
    chk("dc_rst_cass", oCASS_IN, 0);
    chk("dc_rst_edge", oEDGE, 0);
`else
    // Two qualifying samples give a rise, visible one cycle after the 2nd strobe.
    step(1'b1, 16'h1000, "rise1");
    chk("rise1_lvl", oCASS_IN, 0);
    step(1'b1, 16'h1000, "rise2");
    chk("rise2_lvl", oCASS_IN, 1);
    chk("rise2_edge", oEDGE, 1);
    step(1'b0, 16'h0000, "idle");
    chk("edge_one_cycle", oEDGE, 0);
    // Samples inside the band, then the fall.
    step(1'b1, 16'h0400, "band_hi");
    step(1'b1, 16'hFC00, "band_lo");
    chk("band_lvl", oCASS_IN, 1);
    step(1'b1, 16'hF000, "fall1");
    step(1'b1, 16'hF000, "fall2");
    chk("fall_lvl", oCASS_IN, 0);
    chk("fall_edge", oEDGE, 1);
    // An aborted debounce gives no edge.
    step(1'b1, 16'h1000, "abort1");
    step(1'b1, 16'h0000, "abort2");
    step(1'b1, 16'h1000, "abort3");
    chk("abort_lvl", oCASS_IN, 0);
    step(1'b1, 16'h0000, "abort4");
    chk("abort_lvl2", oCASS_IN, 0);
    // Period: 4 samples already since the fall; add 4 more with idle gaps,
    // then 2 to rise = 10.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'h0000, "per_fill");
      step(1'b0, 16'h0000, "per_idle");
    end
    step(1'b1, 16'h1000, "per_r1");
    step(1'b1, 16'h1000, "per_r2");
    chk("period10", oPERIOD, 10);
    chk("period10_edge", oEDGE, 1);
    // Overflow: 5000 samples without an edge.
    for (int i = 0; i < 5000; i++) step(1'b1, 16'h0000, "ovf_fill");
    chk("ovf_set", oOVF, 1);
    chk("ovf_period_held", oPERIOD, 10);
    step(1'b1, 16'hF000, "ovf_f1");
    step(1'b1, 16'hF000, "ovf_f2");
    chk("ovf_period", oPERIOD, 4095);
    chk("ovf_clr", oOVF, 0);
    // A reset in the middle of a debounce discards the pending rise.
    step(1'b1, 16'h1000, "rst_pend");
    doReset();
    step(1'b1, 16'h1000, "rst_after1");
    chk("rst_no_edge", oEDGE, 0);
    chk("rst_lvl", oCASS_IN, 0);
`endif

    // Randomized mix of sample classes and strobe gaps.
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] s;
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: s = 16'($urandom_range(2049, 32767));
        3, 4, 5: s = 16'(-$urandom_range(2049, 32768));
        6:       s = 16'($urandom_range(0, 4096) - 2048);
        7:       s = (($urandom_range(0, 1)) != 0) ? 16'h0800 : 16'hF800;
        8:       s = (($urandom_range(0, 1)) != 0) ? 16'h0801 : 16'hF7FF;
        default: s = 16'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), s, "rand");
      if (i % 1500 == 1499) doReset();
    end

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
